// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester tags.
// Tags 0..CORE_COUNT-1 name cores; tag CORE_COUNT names the UART host port.
package dmem_arb_pkg;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ARB    = 1'b0;
  localparam arb_state_t LOCKED = 1'b1;

  function automatic int tag_width(input int core_count);
    return $clog2(core_count + 1);
  endfunction

  function automatic int host_tag(input int core_count);
    return core_count;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// Zero latency; vld low when no request is present.
module rr_select #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          vld,
  output logic [PW-1:0] idx
);

  always_comb begin
    int j;
    j   = 0;
    vld = 1'b0;
    idx = '0;
    // Walk offsets from farthest to nearest so the nearest request overwrites.
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        vld = 1'b1;
        idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: host-priority, round-robin cores, bounded core lock.
// Grants are combinational; mem_* registered one cycle later; read data returns tagged.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int CORE_COUNT = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LATENCY = 1,
  parameter int LOCK_LIMIT = 16
) (
  input  logic                                  clk,
  input  logic                                  rstN,
  input  logic                                  host_req,
  input  logic                                  host_wrEn,
  input  logic [ADDR_WIDTH-1:0]                 host_addr,
  input  logic [DATA_WIDTH-1:0]                 host_dataIn,
  output logic                                  host_grant,
  output logic                                  host_rdValid,
  input  logic [CORE_COUNT-1:0]                 core_req,
  input  logic [CORE_COUNT-1:0]                 core_wrEn,
  input  logic [CORE_COUNT-1:0]                 core_lock,
  input  logic [CORE_COUNT-1:0][ADDR_WIDTH-1:0] core_addr,
  input  logic [CORE_COUNT-1:0][DATA_WIDTH-1:0] core_dataIn,
  output logic [CORE_COUNT-1:0]                 core_grant,
  output logic [CORE_COUNT-1:0]                 core_rdValid,
  output logic [DATA_WIDTH-1:0]                 rdData,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic                                  mem_wrEn,
  output logic [DATA_WIDTH-1:0]                 mem_dataIn,
  input  logic [DATA_WIDTH-1:0]                 mem_dataOut
);

  localparam int PW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int TW = tag_width(CORE_COUNT);
  localparam int CW = $clog2(LOCK_LIMIT + 1);
  localparam logic [TW-1:0] HOST_TAG = TW'(host_tag(CORE_COUNT));

  arb_state_t      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [CW-1:0]   lock_cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            pick_vld;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   csel;
  logic            any_grant;
  logic            sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [RD_LATENCY:0] pipe_vld;
  logic [TW-1:0]       pipe_tag [0:RD_LATENCY];
  logic                rd_vld;
  logic [TW-1:0]       rd_tag;

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
    return (w == PW'(CORE_COUNT - 1)) ? '0 : w + 1'b1;
  endfunction

  rr_select #(.N(CORE_COUNT), .PW(PW)) u_rr_select (
    .req (core_req),
    .ptr (rr_ptr),
    .vld (pick_vld),
    .idx (pick)
  );

  assign csel    = (state == LOCKED) ? owner : pick;
  assign cnt_nxt = lock_cnt + 1'b1;

  always_comb begin
    host_grant = 1'b0;
    core_grant = '0;
    if (rstN) begin
      if (state == ARB) begin
        if (host_req)      host_grant       = 1'b1;
        else if (pick_vld) core_grant[pick] = 1'b1;
      end else if (core_req[owner]) begin
        core_grant[owner] = 1'b1;
      end
    end
  end

  assign any_grant = host_grant | (|core_grant);
  assign sel_wr    = host_grant ? host_wrEn   : core_wrEn[csel];
  assign sel_addr  = host_grant ? host_addr   : core_addr[csel];
  assign sel_data  = host_grant ? host_dataIn : core_dataIn[csel];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else if (state == ARB) begin
      if (|core_grant) begin
        rr_ptr <= ptr_after(csel);
        if (core_lock[csel] && LOCK_LIMIT > 1) begin
          state    <= LOCKED;
          owner    <= csel;
          lock_cnt <= CW'(1);
        end
      end
    end else begin
      // Release leaves rr_ptr just past the owner so it drops to lowest core priority.
      if (|core_grant) begin
        lock_cnt <= cnt_nxt;
        if (!core_lock[owner] || cnt_nxt == CW'(LOCK_LIMIT)) begin
          state    <= ARB;
          lock_cnt <= '0;
          rr_ptr   <= ptr_after(owner);
        end
      end else if (!core_lock[owner]) begin
        state    <= ARB;
        lock_cnt <= '0;
        rr_ptr   <= ptr_after(owner);
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem_addr   <= '0;
      mem_wrEn   <= 1'b0;
      mem_dataIn <= '0;
    end else if (any_grant) begin
      mem_addr   <= sel_addr;
      mem_wrEn   <= sel_wr;
      mem_dataIn <= sel_data;
    end else begin
      mem_wrEn   <= 1'b0;
    end
  end

  // Stage k holds the tag of the read whose data appears k cycles after mem_addr.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pipe_vld <= '0;
      for (int k = 0; k <= RD_LATENCY; k++) pipe_tag[k] <= '0;
    end else begin
      pipe_vld[0] <= any_grant & ~sel_wr;
      pipe_tag[0] <= host_grant ? HOST_TAG : TW'(csel);
      for (int k = 1; k <= RD_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
    end
  end

  assign rd_vld       = pipe_vld[RD_LATENCY];
  assign rd_tag       = pipe_tag[RD_LATENCY];
  assign host_rdValid = rd_vld && (rd_tag == HOST_TAG);
  assign rdData       = rd_vld ? mem_dataOut : '0;

  always_comb begin
    core_rdValid = '0;
    for (int i = 0; i < CORE_COUNT; i++) core_rdValid[i] = rd_vld && (rd_tag == TW'(i));
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed traffic, expected grant order and read returns
// queued by the stimulus side, checked by a negedge monitor against a behavioural memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int CC = 2, AW = 12, DW = 12, RL = 1, LL = 16;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic                  host_req, host_wrEn, host_grant, host_rdValid;
  logic [AW-1:0]         host_addr;
  logic [DW-1:0]         host_dataIn;
  logic [CC-1:0]         core_req, core_wrEn, core_lock, core_grant, core_rdValid;
  logic [CC-1:0][AW-1:0] core_addr;
  logic [CC-1:0][DW-1:0] core_dataIn;
  logic [DW-1:0]         rdData, mem_dataIn;
  logic [DW-1:0]         mem_dataOut = '0;
  logic [AW-1:0]         mem_addr;
  logic                  mem_wrEn;

  dmem_arbiter #(.CORE_COUNT(CC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                 .RD_LATENCY(RL), .LOCK_LIMIT(LL)) dut (
    .clk(clk), .rstN(rstN),
    .host_req(host_req), .host_wrEn(host_wrEn), .host_addr(host_addr),
    .host_dataIn(host_dataIn), .host_grant(host_grant), .host_rdValid(host_rdValid),
    .core_req(core_req), .core_wrEn(core_wrEn), .core_lock(core_lock),
    .core_addr(core_addr), .core_dataIn(core_dataIn), .core_grant(core_grant),
    .core_rdValid(core_rdValid), .rdData(rdData), .mem_addr(mem_addr),
    .mem_wrEn(mem_wrEn), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  // Behavioural single-port synchronous memory, one cycle read latency.
  logic [DW-1:0] mem    [0:4095];
  logic [DW-1:0] shadow [0:4095];
  always @(posedge clk) begin
    mem_dataOut <= mem[mem_addr];
    if (mem_wrEn) mem[mem_addr] = mem_dataIn;
  end

  typedef struct { int id; logic [DW-1:0] data; int due; } rd_exp_t;
  int      exp_g[$];
  rd_exp_t exp_r[$];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic          g_s    [3];
  int            n_left [3];
  logic [AW-1:0] r_addr [3];
  logic [DW-1:0] r_data [3];
  logic          r_wr   [3];
  logic          r_lock [3];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every grant pops the expected order; every rdValid pops the expected return.
  always @(negedge clk) begin
    logic [2:0] gv, rv;
    int got, e;
    rd_exp_t x;
    gv = {host_grant, core_grant};
    rv = {host_rdValid, core_rdValid};
    for (int r = 0; r < 3; r++) g_s[r] = rstN && gv[r];
    if (rstN) begin
      if ($countones(gv) > 1) begin
        chk("grant_onehot", $countones(gv), 1);
      end else if (gv != 3'b000) begin
        got = gv[2] ? 2 : (gv[1] ? 1 : 0);
        if (exp_g.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_grant: got requester %0d expected none (cycle %0d)", got, cyc);
        end else begin
          e = exp_g.pop_front();
          chk("grant_order", got, e);
          if (r_wr[e]) shadow[r_addr[e]] = r_data[e];
          else exp_r.push_back('{e, shadow[r_addr[e]], cyc + 2});
        end
      end
      if (rv != 3'b000) begin
        if (exp_r.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rdvalid: got %b expected none (cycle %0d)", rv, cyc);
        end else begin
          x = exp_r.pop_front();
          chk("rd_valid_vec", 32'(rv), 32'(1) << x.id);
          chk("rd_data", rdData, x.data);
          chk("rd_cycle", cyc, x.due);
        end
      end
    end
  end

  task automatic apply();
    host_req    = n_left[2] > 0;
    host_wrEn   = r_wr[2];
    host_addr   = r_addr[2];
    host_dataIn = r_data[2];
    for (int i = 0; i < CC; i++) begin
      core_req[i]    = n_left[i] > 0;
      core_wrEn[i]   = r_wr[i];
      core_lock[i]   = r_lock[i] && (n_left[i] > 0);
      core_addr[i]   = r_addr[i];
      core_dataIn[i] = r_data[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) if (g_s[r] && n_left[r] > 0) n_left[r]--;
    apply();
  endtask

  task automatic issue(input int r, input int n, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic wr, input logic lk);
    n_left[r] = n; r_addr[r] = a; r_data[r] = d; r_wr[r] = wr; r_lock[r] = lk;
    apply();
  endtask

  task automatic expect_g(input int id, input int n);
    repeat (n) exp_g.push_back(id);
  endtask

  function automatic bit busy();
    return (n_left[0] > 0) || (n_left[1] > 0) || (n_left[2] > 0);
  endfunction

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((exp_g.size() != 0 || exp_r.size() != 0 || busy()) && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got %0d grants / %0d reads outstanding expected 0",
               nm, exp_g.size(), exp_r.size());
    end
    repeat (3) step();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_grants"}, {host_grant, core_grant}, 0);
    chk({nm, "_rdvalid"}, {host_rdValid, core_rdValid}, 0);
    chk({nm, "_mem_wren"}, mem_wrEn, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_datain"}, mem_dataIn, 0);
    chk({nm, "_rddata"}, rdData, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = DW'(i * 7 + 3);
      shadow[i] = mem[i];
    end
    for (int r = 0; r < 3; r++) begin
      n_left[r] = 0; r_addr[r] = '0; r_data[r] = '0; r_wr[r] = 1'b0; r_lock[r] = 1'b0;
    end
    apply();
    host_req = 1'b1;
    core_req = '1;

    // Reset: requests present but everything held at zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_state", dut.state, ARB);
    chk("reset_rr_ptr", dut.rr_ptr, 0);
    chk("reset_lock_cnt", dut.lock_cnt, 0);
    @(posedge clk);
    #1;
    apply();
    rstN = 1'b1;
    step();

    // Two cores reading every cycle alternate, each read returns two cycles later.
    for (int i = 0; i < 4; i++) begin
      expect_g(0, 1);
      expect_g(1, 1);
    end
    issue(0, 4, 12'd5, '0, 1'b0, 1'b0);
    issue(1, 4, 12'd9, '0, 1'b0, 1'b0);
    drain("alternate");
    chk("alt_rr_ptr", dut.rr_ptr, 0);

    // Host write beats both cores; core0 then reads back the written word.
    expect_g(2, 1);
    expect_g(0, 1);
    expect_g(1, 1);
    issue(2, 1, 12'd5, 12'h5A5, 1'b1, 1'b0);
    issue(0, 1, 12'd5, '0, 1'b0, 1'b0);
    issue(1, 1, 12'd9, '0, 1'b0, 1'b0);
    step();
    chk("host_keeps_rr_ptr", dut.rr_ptr, 0);
    drain("host_first");

    // Core1 locked writes: 16 grants, forced release, core0, then core1 relocks.
    expect_g(1, 16);
    expect_g(0, 1);
    expect_g(1, 4);
    issue(1, 20, 12'h040, 12'h111, 1'b1, 1'b1);
    step();
    step();
    issue(0, 1, 12'd9, '0, 1'b0, 1'b0);
    drain("lock_limit");
    chk("lock_limit_state", dut.state, ARB);
    chk("lock_limit_rr_ptr", dut.rr_ptr, 0);

    // Core0 locks for three reads while the host waits, host follows the release.
    expect_g(0, 3);
    expect_g(2, 1);
    issue(0, 3, 12'd5, '0, 1'b0, 1'b1);
    step();
    issue(2, 1, 12'h020, '0, 1'b0, 1'b0);
    drain("lock_release");
    chk("release_state", dut.state, ARB);

    // Reset one cycle after a read grant discards the pending return.
    expect_g(0, 1);
    issue(0, 1, 12'd9, '0, 1'b0, 1'b0);
    step();
    rstN = 1'b0;
    host_req = 1'b1;
    core_req = '1;
    #2;
    chk_reset_outputs("midreset");
    exp_r.delete();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    apply();
    repeat (4) step();
    chk("midreset_state", dut.state, ARB);
    chk("midreset_rr_ptr", dut.rr_ptr, 0);
    chk("midreset_grants_left", exp_g.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter CORE_COUNT, default 2, number of core requesters.
REQ-002 Parameter ADDR_WIDTH, default 12, data memory address width.
REQ-003 Parameter DATA_WIDTH, default 12, per-requester word width.
REQ-004 Parameter RD_LATENCY, default 1, cycles from mem_addr registered output to valid mem_dataOut.
REQ-005 Parameter LOCK_LIMIT, default 16, maximum consecutive grants held under lock.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rstN  in  1  reset, asynchronous, active-low.
REQ-008 host_req / host_wrEn  in  1 each  UART-side access request and write flag.
REQ-009 host_addr  in  ADDR_WIDTH; host_dataIn  in  DATA_WIDTH.
REQ-010 host_grant  out  1  host access accepted this cycle; host_rdValid  out  1  host read data valid.
REQ-011 core_req, core_wrEn, core_lock  in  CORE_COUNT  per-core request, write flag, hold-ownership.
REQ-012 core_addr  in  CORE_COUNT x ADDR_WIDTH; core_dataIn  in  CORE_COUNT x DATA_WIDTH.
REQ-013 core_grant, core_rdValid  out  CORE_COUNT  per-core accept pulse and read-valid pulse.
REQ-014 rdData  out  DATA_WIDTH  shared read return bus, meaningful only with an rdValid pulse.
REQ-015 mem_addr  out  ADDR_WIDTH; mem_wrEn  out  1; mem_dataIn  out  DATA_WIDTH (all registered).
REQ-016 mem_dataOut  in  DATA_WIDTH  single-port synchronous memory read data.

Function
REQ-017 At most one grant (host_grant or any core_grant bit) SHALL be asserted per cycle; grants are combinational from requests and state.
REQ-018 A requester SHALL hold req, wrEn, addr, dataIn stable until the cycle its grant is high; the access is consumed at that edge.
REQ-019 In granted cycle N, the arbiter SHALL register the winner's addr/dataIn/wrEn onto mem_* for cycle N+1; with no grant, mem_wrEn SHALL be 0 in N+1 and mem_addr SHALL hold.
REQ-020 For a granted read, the matching rdValid SHALL pulse exactly once in cycle N+1+RD_LATENCY with rdData = mem_dataOut; writes produce no rdValid.
REQ-021 Requester tags SHALL travel in a RD_LATENCY-deep pipeline so back-to-back reads from different requesters return in order, one per cycle.
REQ-022 FSM states ARB and LOCKED; reset state ARB.
REQ-023 ARB: host_req SHALL win over all cores; otherwise cores SHALL be served round-robin starting at rr_ptr.
REQ-024 After a core grant in ARB, rr_ptr SHALL become (winner+1) mod CORE_COUNT; host grants SHALL not move rr_ptr.
REQ-025 ARB -> LOCKED when a core is granted with its core_lock high; lock_cnt SHALL load 1 and owner SHALL be recorded.
REQ-026 LOCKED: only the owner SHALL be granted (host and other cores wait); each owner grant increments lock_cnt.
REQ-027 LOCKED -> ARB when owner core_lock is low in any cycle, or on the owner grant where lock_cnt reaches LOCK_LIMIT (forced release, no further owner grant that cycle).
REQ-028 On exit from LOCKED, rr_ptr SHALL be owner+1 mod CORE_COUNT, so the releasing core has lowest core priority.
REQ-029 A requester idle in LOCKED (owner core_req low, core_lock high) SHALL keep the lock without grants; lock_cnt counts grants, not cycles.
REQ-030 Simultaneous host_req and locked-owner request: owner wins; host wins on the first ARB cycle after release.

Reset
REQ-031 While rstN is low: state ARB, rr_ptr 0, lock_cnt 0, tag pipeline empty, all grants 0, all rdValid 0, mem_wrEn 0, mem_addr 0, mem_dataIn 0, rdData 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight reads; no rdValid pulse after rstN rises for pre-reset grants.

Structure
REQ-033 Shared package dmem_arb_pkg SHALL hold the arb_state_t typedef (ARB, LOCKED) and the requester-tag encoding (host = CORE_COUNT).
REQ-034 One sub-module, rr_select, SHALL implement the combinational round-robin pick from a request vector and pointer.

Verification
REQ-035 Core0 and core1 read addr 5 and 9 every cycle, RD_LATENCY 1 -> grants alternate 0,1,0,1; rdValid 2 cycles after each grant with the matching word.
REQ-036 host_req with core0_req same cycle in ARB -> host_grant first; core0_grant next cycle; rr_ptr unchanged by host grant.
REQ-037 Core1 locked writes, 20 requests, LOCK_LIMIT 16 -> 16 consecutive core1 grants, forced release, pending core0 granted next, then core1.
REQ-038 Core0 locks, drops core_lock after 3 grants while host waits -> host_grant on the first cycle after release.
REQ-039 rstN pulsed low one cycle after a core read grant -> no rdValid, all outputs 0 during reset, ARB and rr_ptr 0 after.
